freq_sel_controller: RTL
========================

FREQ_SEL_CONTROLLER -- requirements
Module: freq_sel_controller

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- HALF_0  50_000_000  half-period in clk cycles for sel 0 (1 Hz)
- HALF_1  25_000_000  half-period for sel 1 (2 Hz)
- HALF_2  10_000_000  half-period for sel 2 (5 Hz)
- HALF_3  5_000_000  half-period for sel 3 (10 Hz)
- DEB_CNT  2_000_000  stable cycles for a debounced button press (20 ms)
- SEC_CNT  100_000_000  clk cycles per second tick
- DWELL_SEC  4  seconds per step in AUTO mode

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-low
- btn_next  in  1  raw async button; advance frequency
- btn_mode  in  1  raw async button; cycle mode
- btn_hold  in  1  raw async level; freeze output while high
- sel_freq  out  2  currently applied frequency index
- mode  out  2  current state encoding
- clk_out  out  1  divided square-wave output

Function
REQ-003 Each button SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level changes only after DEB_CNT consecutive equal synchronized samples.
REQ-004 A press SHALL be a debounced 0->1 edge, a 1-cycle internal pulse; holding a button SHALL produce exactly one pulse.
REQ-005 FSM states SHALL be MANUAL=0, AUTO=1, PAUSE=2; encoding 3 is unused and SHALL return to MANUAL on the next clock.
REQ-006 A mode press SHALL go MANUAL->AUTO->PAUSE->MANUAL.
REQ-007 MANUAL: a next press SHALL set pending_sel = (pending_sel+1) mod 4, wrapping 3->0.
REQ-008 AUTO: a 1 s tick SHALL be produced every SEC_CNT cycles; after DWELL_SEC ticks pending_sel SHALL increment mod 4 and the dwell counter SHALL clear; a next press in AUTO SHALL increment immediately and clear the dwell and second counters.
REQ-009 PAUSE: pending_sel SHALL be frozen, next presses ignored, and clk_out held at its current level with the half-period counter frozen.
REQ-010 btn_hold (debounced level) high SHALL behave as PAUSE without changing mode; on release the counter resumes from its frozen value.
REQ-011 Divider: half-period counter counts 1..HALF_sel_freq; at terminal count clk_out toggles and the counter reloads to 1.
REQ-012 pending_sel SHALL be copied to sel_freq only in the cycle clk_out toggles (glitch-free: no truncated half-period); the new HALF applies from the next half-period.
REQ-013 Mode and next presses in the same cycle: the mode transition SHALL win and the next press is dropped.
REQ-014 Entering AUTO from PAUSE SHALL NOT occur (order fixed); entering AUTO SHALL clear the second and dwell counters.
REQ-015 Counter widths SHALL be derived from the parameters with $clog2; no overflow at default values (26-bit divider, 27-bit second counter).

Reset
REQ-016 While rst is low: sel_freq=0, pending_sel=0, mode=MANUAL, clk_out=0, divider counter=1, all debounce, second and dwell counters=0, synchronizers=0.
REQ-017 Reset assertion mid-half-period SHALL abort immediately; after release the first clk_out rising edge occurs HALF_0 cycles later.

Structure
REQ-018 Shared package freq_sel_pkg SHALL hold the mode encodings MANUAL/AUTO/PAUSE and the default HALF_x constants.
REQ-019 Sub-module btn_debounce (synchronizer + debouncer + rise pulse, parameter DEB_CNT) SHALL be instantiated three times; the divider and FSM stay in the top.

Verification (scaled: HALF=50/25/10/5, DEB_CNT=4, SEC_CNT=100, DWELL_SEC=2)
REQ-020 Reset release, no buttons -> clk_out toggles every 50 cycles, sel_freq=0, mode=0.
REQ-021 btn_next glitch 2 cycles, then a clean 10-cycle press -> glitch ignored; sel_freq becomes 1 only at the next clk_out toggle; subsequent half-periods are 25 cycles.
REQ-022 Four clean next presses -> sel_freq wraps 0->1->2->3->0.
REQ-023 Mode press -> AUTO; sel_freq advances every 200 cycles (applied at a toggle boundary); second mode press -> PAUSE, clk_out and sel_freq frozen for 500 cycles.
REQ-024 btn_mode and btn_next pressed together in MANUAL -> mode=AUTO, pending_sel unchanged.
REQ-025 rst low 3 cycles mid-half-period at sel 3 -> all outputs per REQ-016 within 0 cycles (async); rising edge after release at 50 cycles.

Source files
------------

// File: rtl/freq_sel_pkg.sv
// Shared definitions for the frequency-select controller.
// Holds the mode encodings, default half-period/debounce/timing constants
// and a small constant helper used to size counters.
package freq_sel_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    PAUSE  = 2'd2
  } mode_e;

  localparam int unsigned HALF_0_DEF    = 50_000_000;  // 1 Hz
  localparam int unsigned HALF_1_DEF    = 25_000_000;  // 2 Hz
  localparam int unsigned HALF_2_DEF    = 10_000_000;  // 5 Hz
  localparam int unsigned HALF_3_DEF    = 5_000_000;   // 10 Hz
  localparam int unsigned DEB_CNT_DEF   = 2_000_000;   // 20 ms
  localparam int unsigned SEC_CNT_DEF   = 100_000_000; // 1 s
  localparam int unsigned DWELL_SEC_DEF = 4;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debouncer and rising-edge pulse.
// Ports: clk, rst (async active-low), btn_raw (asynchronous input),
//        level (debounced level), press (1-cycle pulse on debounced 0->1).
module btn_debounce
  import freq_sel_pkg::*;
#(
  parameter int unsigned DEB_CNT = DEB_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = max2(1, $clog2(DEB_CNT));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // Level flips only after DEB_CNT consecutive samples that differ from it.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/freq_sel_controller.sv
// Frequency-select controller: MANUAL/AUTO/PAUSE mode FSM choosing one of four
// half-periods for a square-wave divider; selection changes only at toggles.
// Ports: clk, rst (async active-low), btn_next/btn_mode/btn_hold (raw async
//        buttons), sel_freq (applied index), mode (state), clk_out (divided clock).
module freq_sel_controller
  import freq_sel_pkg::*;
#(
  parameter int unsigned HALF_0    = HALF_0_DEF,
  parameter int unsigned HALF_1    = HALF_1_DEF,
  parameter int unsigned HALF_2    = HALF_2_DEF,
  parameter int unsigned HALF_3    = HALF_3_DEF,
  parameter int unsigned DEB_CNT   = DEB_CNT_DEF,
  parameter int unsigned SEC_CNT   = SEC_CNT_DEF,
  parameter int unsigned DWELL_SEC = DWELL_SEC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_mode,
  input  logic       btn_hold,
  output logic [1:0] sel_freq,
  output logic [1:0] mode,
  output logic       clk_out
);

  localparam int unsigned HALF_MAX = max2(max2(HALF_0, HALF_1), max2(HALF_2, HALF_3));
  localparam int unsigned DIV_W    = $clog2(HALF_MAX + 1);
  localparam int unsigned SEC_W    = max2(1, $clog2(SEC_CNT));
  localparam int unsigned DWELL_W  = max2(1, $clog2(DWELL_SEC));
  localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(SEC_CNT - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_SEC - 1);

  logic next_press, mode_press, hold_lvl;
  logic next_lvl, mode_lvl, hold_press;
  logic unused_btn;

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_next (
    .clk(clk), .rst(rst), .btn_raw(btn_next), .level(next_lvl), .press(next_press)
  );
  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_mode (
    .clk(clk), .rst(rst), .btn_raw(btn_mode), .level(mode_lvl), .press(mode_press)
  );
  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_hold (
    .clk(clk), .rst(rst), .btn_raw(btn_hold), .level(hold_lvl), .press(hold_press)
  );

  // Only presses of next/mode and the level of hold are meaningful here.
  assign unused_btn = next_lvl ^ mode_lvl ^ hold_press;

  mode_e              mode_q, mode_d;
  logic [1:0]         pend_q, pend_d;
  logic [1:0]         sel_q, sel_d;
  logic               clk_out_q, clk_out_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DIV_W-1:0]   half_c;
  logic               frozen_c;

  always_comb begin
    mode_d    = mode_q;
    pend_d    = pend_q;
    sel_d     = sel_q;
    clk_out_d = clk_out_q;
    div_d     = div_q;
    sec_d     = sec_q;
    dwell_d   = dwell_q;
    frozen_c  = (mode_q == PAUSE) || hold_lvl;

    case (sel_q)
      2'd0:    half_c = DIV_W'(HALF_0);
      2'd1:    half_c = DIV_W'(HALF_1);
      2'd2:    half_c = DIV_W'(HALF_2);
      default: half_c = DIV_W'(HALF_3);
    endcase

    // Mode FSM; a mode press always takes precedence over a next press.
    case (mode_q)
      MANUAL: begin
        if (mode_press) begin
          mode_d  = AUTO;
          sec_d   = '0;
          dwell_d = '0;
        end else if (next_press && !hold_lvl) begin
          pend_d = pend_q + 2'd1;
        end
      end
      AUTO: begin
        if (mode_press) begin
          mode_d = PAUSE;
        end else if (!hold_lvl) begin
          if (next_press) begin
            pend_d  = pend_q + 2'd1;
            sec_d   = '0;
            dwell_d = '0;
          end else if (sec_q == SEC_LAST) begin
            sec_d = '0;
            if (dwell_q == DWELL_LAST) begin
              dwell_d = '0;
              pend_d  = pend_q + 2'd1;
            end else begin
              dwell_d = dwell_q + DWELL_W'(1);
            end
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end
      end
      PAUSE: begin
        if (mode_press) begin
          mode_d = MANUAL;
        end
      end
      default: mode_d = MANUAL;
    endcase

    // Divider; a new selection is taken only on a toggle so no half-period is cut short.
    if (!frozen_c) begin
      if (div_q == half_c) begin
        clk_out_d = ~clk_out_q;
        div_d     = DIV_W'(1);
        sel_d     = pend_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MANUAL;
      pend_q    <= 2'd0;
      sel_q     <= 2'd0;
      clk_out_q <= 1'b0;
      div_q     <= DIV_W'(1);
      sec_q     <= '0;
      dwell_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      sel_q     <= sel_d;
      clk_out_q <= clk_out_d;
      div_q     <= div_d;
      sec_q     <= sec_d;
      dwell_q   <= dwell_d;
    end
  end

  assign sel_freq = sel_q;
  assign mode     = mode_q;
  assign clk_out  = clk_out_q;

endmodule
